// File: rtl/rx_dma_arb_pkg.sv
// Shared types and constants for the S2MM stream arbiter between the
// packet path and the IQ capture path.
package rx_dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } arb_state_t;

    localparam int GRANT_PKT       = 0;
    localparam int GRANT_IQ        = 1;
    localparam int ABORT_CNT_WIDTH = 16;

    function automatic logic [1:0] grant_onehot(input logic idx);
        logic [1:0] g;
        g = '0;
        if (idx) g[GRANT_IQ] = 1'b1;
        else     g[GRANT_PKT] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/rx_dma_stall_timer.sv
// Saturating 1 us stall counter; expires once the count exceeds a nonzero
// limit. A zero limit disables expiry.
module rx_dma_stall_timer #(
    parameter int TIMEOUT_WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     tick,
    input  logic                     enable,
    input  logic [TIMEOUT_WIDTH-1:0] top,
    output logic                     expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (top != '0) && (count > top);

endmodule

// File: rtl/rx_dma_arbiter.sv
// Whole-frame arbiter sharing one S2MM stream between the packet path (0)
// and the IQ capture path (1), with tlast generation and stall recovery.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no frame owned; pick a winner among eligible requests
//   ST_STREAM | forwarding beats of the granted source, counting down length
//   ST_FLUSH  | source stalled too long; emit one zero beat with tlast
module rx_dma_arbiter
    import rx_dma_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int LEN_WIDTH     = 14,
    parameter int TIMEOUT_WIDTH = 13
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       tsf_pulse_1M,
    input  logic [TIMEOUT_WIDTH-1:0]   timeout_top,
    input  logic                       rr_mode,
    input  logic [1:0]                 req,
    input  logic [LEN_WIDTH-1:0]       req_len0,
    input  logic [LEN_WIDTH-1:0]       req_len1,
    output logic [1:0]                 grant,
    input  logic [DATA_WIDTH-1:0]      s_data0,
    input  logic [DATA_WIDTH-1:0]      s_data1,
    input  logic                       s_valid0,
    input  logic                       s_valid1,
    output logic                       s_ready0,
    output logic                       s_ready1,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       frame_done,
    output logic                       frame_abort,
    output logic [ABORT_CNT_WIDTH-1:0] abort_cnt
);

    arb_state_t           state;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 rr_ptr;
    logic                 gidx;
    logic                 elig0;
    logic                 elig1;
    logic                 winner;
    logic                 hs;
    logic                 expired;

    assign gidx  = grant[GRANT_IQ];
    assign elig0 = req[0] && (req_len0 != '0);
    assign elig1 = req[1] && (req_len1 != '0);
    // Under round-robin the pointer holds the last served index, so the other one wins.
    assign winner = (elig0 && elig1) ? (rr_mode ? ~rr_ptr : 1'b0) : elig1;
    assign hs     = m_axis_tvalid && m_axis_tready;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_ready0      = 1'b0;
        s_ready1      = 1'b0;
        case (state)
            ST_STREAM: begin
                m_axis_tdata  = gidx ? s_data1 : s_data0;
                m_axis_tvalid = gidx ? s_valid1 : s_valid0;
                m_axis_tlast  = m_axis_tvalid && (remaining == LEN_WIDTH'(1));
                s_ready0      = !gidx && m_axis_tready;
                s_ready1      = gidx && m_axis_tready;
            end
            ST_FLUSH: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    rx_dma_stall_timer #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_stall_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clear  ((state != ST_STREAM) || hs),
        .tick   (tsf_pulse_1M),
        .enable (state == ST_STREAM),
        .top    (timeout_top),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            grant       <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            abort_cnt   <= '0;
            rr_ptr      <= 1'b0;
            remaining   <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (elig0 || elig1) begin
                        grant     <= grant_onehot(winner);
                        remaining <= winner ? req_len1 : req_len0;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // A beat landing in the expiry cycle keeps the frame alive.
                    if (hs) begin
                        if (remaining != '0) remaining <= remaining - 1'b1;
                        if (remaining == LEN_WIDTH'(1)) begin
                            grant      <= '0;
                            frame_done <= 1'b1;
                            rr_ptr     <= gidx;
                            state      <= ST_IDLE;
                        end
                    end else if (expired) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (m_axis_tready) begin
                        grant       <= '0;
                        frame_abort <= 1'b1;
                        if (abort_cnt != '1) abort_cnt <= abort_cnt + 1'b1;
                        rr_ptr      <= gidx;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_dma_arbiter.sv
// Scoreboard bench for rx_dma_arbiter: a frame-level model predicts the beat
// sequence on m_axis; a negedge monitor pops and compares every transfer.
module tb_rx_dma_arbiter;

    localparam int DW = 64;
    localparam int LW = 14;
    localparam int TW = 13;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          tsf_pulse_1M = 1'b0;
    logic [TW-1:0] timeout_top = '0;
    logic          rr_mode = 1'b0;
    logic [1:0]    req = '0;
    logic [LW-1:0] req_len0 = '0;
    logic [LW-1:0] req_len1 = '0;
    logic [1:0]    grant;
    logic [DW-1:0] s_data0 = '0;
    logic [DW-1:0] s_data1 = '0;
    logic          s_valid0 = 1'b0;
    logic          s_valid1 = 1'b0;
    logic          s_ready0;
    logic          s_ready1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic          frame_done;
    logic          frame_abort;
    logic [15:0]   abort_cnt;

    rx_dma_arbiter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tsf_pulse_1M (tsf_pulse_1M),
        .timeout_top  (timeout_top),
        .rr_mode      (rr_mode),
        .req          (req),
        .req_len0     (req_len0),
        .req_len1     (req_len1),
        .grant        (grant),
        .s_data0      (s_data0),
        .s_data1      (s_data1),
        .s_valid0     (s_valid0),
        .s_valid1     (s_valid1),
        .s_ready0     (s_ready0),
        .s_ready1     (s_ready1),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .abort_cnt    (abort_cnt)
    );

    always #5 clk = ~clk;

    // 1 us tick compressed to one pulse every 4 clocks
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 tsf_pulse_1M = 1'b1;
            @(posedge clk);
            #1 tsf_pulse_1M = 1'b0;
        end
    end

    typedef struct {
        logic [63:0] data;
        bit          last;
        int          src;     // 0/1 requester, 2 = fake flush beat
        int          pulses;  // ticks expected between last real beat and flush
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    model_ptr = 0;
    int    model_aborts = 0;
    int    len_q0[$];
    int    len_q1[$];
    bit    exp_done = 1'b0;
    bit    exp_abort = 1'b0;
    int    pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [63:0] d, input bit last, input int src, input int p);
        beat_t e;
        e.data = d;
        e.last = last;
        e.src = src;
        e.pulses = p;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every m_axis transfer and the pulses that follow it.
    always @(negedge clk) begin
        bit    hs;
        bit    nd;
        bit    na;
        beat_t e;
        if (!rstn) begin
            exp_done  = 1'b0;
            exp_abort = 1'b0;
            pulses    = 0;
        end else begin
            if (frame_done || exp_done) check("frame_done", 64'(frame_done), 64'(exp_done));
            if (frame_abort || exp_abort) check("frame_abort", 64'(frame_abort), 64'(exp_abort));
            if (exp_done || exp_abort) check("idle_gap_grant_tvalid", {grant, m_axis_tvalid}, 3'b000);
            nd = 1'b0;
            na = 1'b0;
            hs = m_axis_tvalid && m_axis_tready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no transfer",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_last", 64'(m_axis_tlast), 64'(e.last));
                    if (e.src == 2) begin
                        check("flush_s_ready", {s_ready1, s_ready0}, 2'b00);
                        check("flush_tick_count", 64'(pulses), 64'(e.pulses));
                        na = 1'b1;
                    end else begin
                        check("beat_s_ready", {s_ready1, s_ready0}, (e.src == 0) ? 2'b01 : 2'b10);
                        nd = e.last;
                    end
                end
                pulses = 0;
            end else if (tsf_pulse_1M) begin
                pulses++;
            end
            exp_done  = nd;
            exp_abort = na;
        end
    end

    // Issues the frames queued in len_q0/len_q1 and predicts the m_axis beat order.
    task automatic run_round(input bit mode, input bit zero1, input int tr_mode, input bit vfull,
                             input int stall_after, input int stall_cyc);
        logic [63:0] d0[$];
        logic [63:0] d1[$];
        int nf0, nf1, f0, f1, b0, b1, w0, w1, i0, i1, o0, o1, ptr, win;
        int cyc, first_g, stalled, budget;
        bit x0, x1, ab, tog, exp_ab, st0;
        nf0 = len_q0.size();
        nf1 = len_q1.size();
        foreach (len_q0[k]) for (int b = 0; b < len_q0[k]; b++) d0.push_back({$urandom, $urandom});
        foreach (len_q1[k]) for (int b = 0; b < len_q1[k]; b++) d1.push_back({$urandom, $urandom});
        exp_ab = (stall_after >= 0) && (stall_cyc == 0) && (timeout_top != '0);

        ptr = model_ptr; i0 = 0; i1 = 0; o0 = 0; o1 = 0;
        while (i0 < nf0 || i1 < nf1) begin
            if (i0 < nf0 && i1 < nf1) win = mode ? (1 - ptr) : 0;
            else                      win = (i0 < nf0) ? 0 : 1;
            if (win == 0) begin
                for (int b = 0; b < len_q0[i0]; b++) begin
                    if (i0 == 0 && exp_ab && b == stall_after) begin
                        push_beat(64'd0, 1'b1, 2, int'(timeout_top) + 1);
                        break;
                    end
                    push_beat(d0[o0 + b], b == len_q0[i0] - 1, 0, 0);
                end
                o0 += len_q0[i0];
                i0++;
            end else begin
                for (int b = 0; b < len_q1[i1]; b++) push_beat(d1[o1 + b], b == len_q1[i1] - 1, 1, 0);
                o1 += len_q1[i1];
                i1++;
            end
            ptr = win;
        end
        model_ptr = ptr;
        if (exp_ab) model_aborts++;

        rr_mode = mode;
        f0 = 0; f1 = 0; b0 = 0; b1 = 0; w0 = 0; w1 = 0;
        cyc = 0; first_g = -1; stalled = 0; tog = 1'b1;
        budget = 2000 + stall_cyc;
        while (cyc < budget) begin
            req[0]   = (f0 < nf0);
            req_len0 = (f0 < nf0) ? LW'(len_q0[f0]) : '0;
            req[1]   = (f1 < nf1) || zero1;
            req_len1 = (f1 < nf1) ? LW'(len_q1[f1]) : '0;
            s_data0  = (w0 < d0.size()) ? d0[w0] : '0;
            s_data1  = (w1 < d1.size()) ? d1[w1] : '0;
            st0 = (f0 == 0) && (stall_after >= 0) && (b0 == stall_after) &&
                  ((stall_cyc == 0) || (stalled < stall_cyc));
            if (st0) stalled++;
            s_valid0 = (f0 < nf0) && !st0 && (vfull || ($urandom_range(3) != 0));
            s_valid1 = (f1 < nf1) && (vfull || ($urandom_range(3) != 0));
            m_axis_tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? tog : ($urandom_range(3) != 0);
            tog = ~tog;
            @(negedge clk);
            x0 = s_valid0 && s_ready0;
            x1 = s_valid1 && s_ready1;
            ab = m_axis_tvalid && m_axis_tready && !s_ready0 && !s_ready1;
            if (grant != 2'b00 && first_g < 0) first_g = cyc;
            @(posedge clk);
            #1;
            cyc++;
            if (x0) begin
                w0++; b0++;
                if (b0 == len_q0[f0]) begin f0++; b0 = 0; end
            end
            if (x1) begin
                w1++; b1++;
                if (b1 == len_q1[f1]) begin f1++; b1 = 0; end
            end
            if (ab && f0 < nf0) begin
                w0 += len_q0[f0] - b0;
                f0++;
                b0 = 0;
            end
            if (f0 == nf0 && f1 == nf1 && exp_q.size() == 0) break;
        end
        if (cyc >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL round_timeout: %0d beats still outstanding after %0d cycles, expected 0",
                     exp_q.size(), cyc);
            exp_q.delete();
        end
        if (nf0 + nf1 > 0) check("grant_latency", 64'(first_g), 64'd1);
        req = '0; req_len0 = '0; req_len1 = '0;
        s_valid0 = 1'b0; s_valid1 = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd[$];
        int idx, nf0, nf1, len;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset_grant", grant, 2'b00);
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tlast", m_axis_tlast, 1'b0);
        check("reset_done_abort", {frame_done, frame_abort}, 2'b00);
        check("reset_abort_cnt", abort_cnt, 16'd0);
        check("reset_s_ready", {s_ready1, s_ready0}, 2'b00);
        @(posedge clk);
        #1;

        // single frame, always valid, tready held high
        len_q0 = '{3}; len_q1 = '{};
        run_round(1'b0, 1'b0, 0, 1'b1, -1, 0);

        // backpressure on requester 1 with alternating tready
        len_q0 = '{}; len_q1 = '{4};
        run_round(1'b0, 1'b0, 1, 1'b1, -1, 0);

        // contention, round-robin then fixed priority
        len_q0 = '{2, 2}; len_q1 = '{2, 2};
        run_round(1'b1, 1'b0, 0, 1'b1, -1, 0);
        len_q0 = '{2, 2}; len_q1 = '{2, 2};
        run_round(1'b0, 1'b0, 0, 1'b1, -1, 0);

        // zero-length request on 1 never wins
        len_q0 = '{3}; len_q1 = '{};
        run_round(1'b1, 1'b1, 0, 1'b1, -1, 0);

        // stall recovery by timeout
        timeout_top = 13'd5;
        len_q0 = '{4}; len_q1 = '{};
        run_round(1'b0, 1'b0, 0, 1'b1, 2, 0);
        check("abort_cnt_after_stall", abort_cnt, 16'(model_aborts));

        // timeout disabled: 1000 ticks of stall must not abort
        timeout_top = 13'd0;
        len_q0 = '{4}; len_q1 = '{};
        run_round(1'b0, 1'b0, 0, 1'b1, 2, 4000);
        check("abort_cnt_no_timeout", abort_cnt, 16'(model_aborts));

        // reset in the middle of a 5-beat frame
        rd.delete();
        for (int b = 0; b < 5; b++) rd.push_back({$urandom, $urandom});
        push_beat(rd[0], 1'b0, 0, 0);
        push_beat(rd[1], 1'b0, 0, 0);
        rr_mode = 1'b0; req = 2'b01; req_len0 = LW'(5);
        s_valid0 = 1'b1; m_axis_tready = 1'b1;
        idx = 0;
        for (int c = 0; c < 50 && idx < 2; c++) begin
            s_data0 = rd[idx];
            @(negedge clk);
            if (s_valid0 && s_ready0) idx++;
            @(posedge clk);
            #1;
        end
        rstn = 1'b0; s_valid0 = 1'b0; m_axis_tready = 1'b0; req = '0; req_len0 = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("midreset_beats_left", 64'(exp_q.size()), 64'd0);
        check("midreset_grant_tvalid", {grant, m_axis_tvalid}, 3'b000);
        check("midreset_abort_cnt", abort_cnt, 16'd0);
        exp_q.delete();
        model_ptr = 0;
        model_aborts = 0;
        @(posedge clk);
        #1;
        len_q0 = '{1}; len_q1 = '{};
        run_round(1'b0, 1'b0, 0, 1'b1, -1, 0);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            len_q0 = '{}; len_q1 = '{};
            if (r % 8 == 7) begin
                len = $urandom_range(8, 2);
                len_q0.push_back(len);
                timeout_top = TW'($urandom_range(9, 2));
                run_round(1'($urandom_range(1)), 1'b0, 0, 1'b1, $urandom_range(len - 1, 1), 0);
            end else begin
                nf0 = $urandom_range(3);
                nf1 = $urandom_range(3);
                if (nf0 + nf1 == 0) nf0 = 1;
                for (int k = 0; k < nf0; k++) len_q0.push_back($urandom_range(8, 1));
                for (int k = 0; k < nf1; k++) len_q1.push_back($urandom_range(8, 1));
                timeout_top = ($urandom_range(1) != 0) ? TW'(40) : TW'(0);
                run_round(1'($urandom_range(1)), (nf1 == 0) && ($urandom_range(1) != 0),
                          $urandom_range(2), 1'b0, -1, 0);
            end
        end
        check("abort_cnt_final", abort_cnt, 16'(model_aborts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
